// File: rtl/icache_sram_pkg.sv
// Shared types and sizes for the instruction-cache SRAM controller slice.
// One 256x20 macro: write port 0 (refill/flush), read port 1 (lookup).
package icache_sram_pkg;

  localparam int DATA_WIDTH = 20;
  localparam int ADDR_WIDTH = 8;

  typedef logic [ADDR_WIDTH-1:0] sram_addr_t;
  typedef logic [DATA_WIDTH-1:0] sram_word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/icache_flush_seq.sv
// Flush sequencer: walks every SRAM address once, then pulses flush_done.
// Owns the IDLE/FLUSH state; the top uses flush_busy to steal port 0.
module icache_flush_seq
  import icache_sram_pkg::*;
#(
  parameter int CNT_WIDTH = ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic [CNT_WIDTH-1:0] flush_addr
);

  ctrl_state_e          state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 last;

  assign last       = &cnt;
  assign flush_busy = (state == FLUSH);
  assign flush_addr = cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= (state == FLUSH) && last;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (flush_req) state <= FLUSH;
        end
        FLUSH: begin
          // Terminal count returns to IDLE, so the wrap to 0 never starts a second pass.
          cnt <= cnt + 1'b1;
          if (last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/icache_sram_ctrl.sv
// Shares one 1R1W SRAM macro between the lookup pipe (reads), the refill
// engine (writes) and the flush sequencer; same-address read/write is bypassed.
module icache_sram_ctrl #(
  parameter int                    DATA_WIDTH = icache_sram_pkg::DATA_WIDTH,
  parameter int                    ADDR_WIDTH = icache_sram_pkg::ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FLUSH_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  logic                  idle;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  collide;
  logic [ADDR_WIDTH-1:0] flush_addr;
  logic                  byp_flag;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [DATA_WIDTH-1:0] rsp_hold;
  logic [DATA_WIDTH-1:0] rsp_now;

  icache_flush_seq #(
    .CNT_WIDTH (ADDR_WIDTH)
  ) u_flush_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .flush_addr (flush_addr)
  );

  // Gating with rst_n keeps both chip selects high while reset is asserted.
  assign idle     = rst_n && !flush_busy;
  assign rd_ready = idle;
  assign wr_ready = idle;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign collide  = rd_fire && wr_fire && (rd_addr == wr_addr);

  // NOTE: every output gets a default before the branches; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    sram_csb0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    sram_csb1  = 1'b1;
    sram_addr1 = '0;
    if (rst_n && flush_busy) begin
      sram_csb0  = 1'b0;
      sram_addr0 = flush_addr;
      sram_din0  = FLUSH_WORD;
    end else if (wr_fire) begin
      sram_csb0  = 1'b0;
      sram_addr0 = wr_addr;
      sram_din0  = wr_data;
    end
    if (rd_fire && !collide) begin
      sram_csb1  = 1'b0;
      sram_addr1 = rd_addr;
    end
  end

  assign rsp_now  = byp_flag ? byp_data : sram_dout1;
  // Live macro data during the response cycle, captured copy afterwards.
  assign rsp_data = rsp_valid ? rsp_now : rsp_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      byp_flag  <= 1'b0;
      byp_data  <= '0;
      rsp_hold  <= '0;
    end else begin
      rsp_valid <= rd_fire;
      byp_flag  <= collide;
      if (collide)   byp_data <= wr_data;
      if (rsp_valid) rsp_hold <= rsp_now;
    end
  end

endmodule
